// File: rtl/sb_rx_transaction_deframer.sv
// Sideband receive deframer: samples sbrx one bit per sb_clk, rebuilds
// UART-style symbols (start, 8 data LSB-first, stop), strips DLE/STX ..
// DLE/ETX framing and DLE stuffing, and emits payload bytes as a strobed
// stream with start/end/error markers.
//
// Output handshake: rx_valid is a one-cycle strobe with no back-pressure.
// rx_data/rx_sop/rx_eop/rx_err are meaningful only while rx_valid is high
// (and read as zero otherwise); rx_type is a level that holds the type of
// the most recent STX.
`timescale 1ns/1ps

module sb_rx_transaction_deframer #(
    parameter int unsigned MAX_LEN = 16,
    parameter logic [7:0]  DLE     = 8'hFE,
    parameter logic [7:0]  STX_CMD = 8'h05,
    parameter logic [7:0]  STX_RSP = 8'h04,
    parameter logic [7:0]  ETX     = 8'h40
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       sbrx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sop,
    output logic       rx_eop,
    output logic       rx_type,
    output logic       rx_err,
    output logic       frame_err
);

    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_STOP  = 2'd2,
        S_BREAK = 2'd3
    } sym_state_t;

    typedef enum logic [1:0] {
        F_IDLE    = 2'd0,
        F_DLE     = 2'd1,
        F_PAY     = 2'd2,
        F_PAY_DLE = 2'd3
    } frm_state_t;

    // Symbol layer state
    sym_state_t sym_state_q, sym_state_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;

    // Frame layer state
    frm_state_t    frm_state_q, frm_state_d;
    logic          held_q, held_d;
    logic [7:0]    held_data_q, held_data_d;
    logic [CW-1:0] count_q, count_d;

    // Registered outputs
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_sop_q, rx_sop_d;
    logic       rx_eop_q, rx_eop_d;
    logic       rx_type_q, rx_type_d;
    logic       rx_err_q, rx_err_d;
    logic       frame_err_q, frame_err_d;

    // Symbol-to-frame events (combinational, valid in the stop-bit cycle)
    logic       byte_done;
    logic       stop_err;
    logic [7:0] rx_byte;

    // Frame decode scratch
    logic       do_accept;
    logic       do_end;
    logic       do_abort;
    logic [7:0] accept_byte;

    assign rx_byte = shift_q;

    // Symbol FSM: next state, bit shifting and stop-bit events
    always_comb begin
        sym_state_d = sym_state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_done   = 1'b0;
        stop_err    = 1'b0;
        case (sym_state_q)
            S_IDLE: begin
                if (!sbrx) begin
                    sym_state_d = S_DATA;
                    bit_idx_d   = 3'd0;
                end
            end
            S_DATA: begin
                shift_d[bit_idx_q] = sbrx;
                if (bit_idx_q == 3'd7) begin
                    sym_state_d = S_STOP;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (sbrx) begin
                    byte_done   = 1'b1;
                    sym_state_d = S_IDLE;
                end else begin
                    stop_err    = 1'b1;
                    sym_state_d = S_BREAK;
                end
            end
            S_BREAK: begin
                // Line held low past the stop bit: wait for it to go idle.
                if (sbrx) begin
                    sym_state_d = S_IDLE;
                end
            end
            default: begin
                sym_state_d = S_IDLE;
            end
        endcase
        // Disabled: the line is ignored and the symbol layer parks in idle.
        if (!enable) begin
            sym_state_d = S_IDLE;
            bit_idx_d   = 3'd0;
            byte_done   = 1'b0;
            stop_err    = 1'b0;
        end
    end

    // Frame FSM: framing/unstuffing, one-byte holdback and output strobes
    always_comb begin
        frm_state_d  = frm_state_q;
        held_d       = held_q;
        held_data_d  = held_data_q;
        count_d      = count_q;
        rx_type_d    = rx_type_q;
        rx_data_d    = 8'h00;
        rx_valid_d   = 1'b0;
        rx_sop_d     = 1'b0;
        rx_eop_d     = 1'b0;
        rx_err_d     = 1'b0;
        frame_err_d  = stop_err;
        do_accept    = 1'b0;
        do_end       = 1'b0;
        do_abort     = 1'b0;
        accept_byte  = rx_byte;

        if (stop_err) begin
            // A broken symbol kills any transaction in progress.
            if (frm_state_q != F_IDLE) begin
                do_abort = 1'b1;
            end
            frm_state_d = F_IDLE;
        end else if (byte_done) begin
            case (frm_state_q)
                F_IDLE: begin
                    if (rx_byte == DLE) begin
                        frm_state_d = F_DLE;
                    end
                end
                F_DLE: begin
                    if (rx_byte == STX_CMD || rx_byte == STX_RSP) begin
                        frm_state_d = F_PAY;
                        rx_type_d   = (rx_byte == STX_RSP);
                        count_d     = '0;
                        held_d      = 1'b0;
                    end else if (rx_byte != DLE) begin
                        frm_state_d = F_IDLE;
                    end
                end
                F_PAY: begin
                    if (rx_byte == DLE) begin
                        frm_state_d = F_PAY_DLE;
                    end else begin
                        do_accept = 1'b1;
                    end
                end
                F_PAY_DLE: begin
                    if (rx_byte == DLE) begin
                        // Stuffed DLE pair carries one literal DLE byte.
                        do_accept   = 1'b1;
                        accept_byte = DLE;
                        frm_state_d = F_PAY;
                    end else if (rx_byte == ETX) begin
                        do_end      = 1'b1;
                        frm_state_d = F_IDLE;
                    end else begin
                        do_abort    = 1'b1;
                        frm_state_d = F_IDLE;
                    end
                end
                default: begin
                    frm_state_d = F_IDLE;
                end
            endcase
        end

        // A byte is held back one slot so the last one can carry rx_eop.
        if (do_accept) begin
            if (count_q == CW'(MAX_LEN)) begin
                do_abort    = 1'b1;
                frm_state_d = F_IDLE;
            end else begin
                if (held_q) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = held_data_q;
                    rx_sop_d   = (count_q == CW'(1));
                end
                held_d      = 1'b1;
                held_data_d = accept_byte;
                count_d     = count_q + CW'(1);
            end
        end

        if (do_end) begin
            if (held_q) begin
                rx_valid_d = 1'b1;
                rx_data_d  = held_data_q;
                rx_sop_d   = (count_q == CW'(1));
                rx_eop_d   = 1'b1;
                held_d     = 1'b0;
                count_d    = '0;
            end else begin
                do_abort = 1'b1;
            end
        end

        // Abort overrides any held-byte emit and discards the held byte.
        if (do_abort) begin
            rx_valid_d = 1'b1;
            rx_data_d  = 8'h00;
            rx_sop_d   = 1'b0;
            rx_eop_d   = 1'b1;
            rx_err_d   = 1'b1;
            held_d     = 1'b0;
            count_d    = '0;
        end

        // Disabled: drop the transaction silently, no abort strobe.
        if (!enable) begin
            frm_state_d = F_IDLE;
            held_d      = 1'b0;
            count_d     = '0;
            rx_valid_d  = 1'b0;
            rx_data_d   = 8'h00;
            rx_sop_d    = 1'b0;
            rx_eop_d    = 1'b0;
            rx_err_d    = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    // Symbol layer registers
    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            sym_state_q <= S_IDLE;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
        end else begin
            sym_state_q <= sym_state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
        end
    end

    // Frame layer and output registers
    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            frm_state_q <= F_IDLE;
            held_q      <= 1'b0;
            held_data_q <= 8'h00;
            count_q     <= '0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_sop_q    <= 1'b0;
            rx_eop_q    <= 1'b0;
            rx_type_q   <= 1'b0;
            rx_err_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frm_state_q <= frm_state_d;
            held_q      <= held_d;
            held_data_q <= held_data_d;
            count_q     <= count_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_sop_q    <= rx_sop_d;
            rx_eop_q    <= rx_eop_d;
            rx_type_q   <= rx_type_d;
            rx_err_q    <= rx_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_sop    = rx_sop_q;
    assign rx_eop    = rx_eop_q;
    assign rx_type   = rx_type_q;
    assign rx_err    = rx_err_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sb_rx_transaction_deframer.sv
// Bench for the sideband receive deframer: serial symbol driver, scoreboard
// of expected strobes (with the cycle each must appear in) and one task per
// scenario.
`timescale 1ns/1ps

module tb_sb_rx_transaction_deframer;

    localparam logic [7:0] DLE     = 8'hFE;
    localparam logic [7:0] STX_CMD = 8'h05;
    localparam logic [7:0] STX_RSP = 8'h04;
    localparam logic [7:0] ETX     = 8'h40;

    logic       sb_clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       sbrx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sop;
    logic       rx_eop;
    logic       rx_type;
    logic       rx_err;
    logic       frame_err;

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    // Entries are {err, eop, sop, type, data}
    logic [11:0] exp_q[$];
    int          cyc_q[$];
    int          ferr_q[$];

    sb_rx_transaction_deframer dut (
        .sb_clk    (sb_clk),
        .rst       (rst),
        .enable    (enable),
        .sbrx      (sbrx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_sop    (rx_sop),
        .rx_eop    (rx_eop),
        .rx_type   (rx_type),
        .rx_err    (rx_err),
        .frame_err (frame_err)
    );

    // Clock and cycle counter
    always #5 sb_clk = ~sb_clk;

    always @(posedge sb_clk) cyc <= cyc + 1;

    function automatic void push_exp(input logic [7:0] d, input logic sop, input logic eop,
                                     input logic typ, input logic err);
        exp_q.push_back({err, eop, sop, typ, d});
    endfunction

    function automatic void flush_queues();
        exp_q.delete();
        cyc_q.delete();
        ferr_q.delete();
    endfunction

    // One 10-bit symbol; the strobe it causes (if any) is due at c0+10.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic want);
        int c0;
        @(posedge sb_clk); #1;
        sbrx = 1'b0;
        c0 = cyc;
        if (want) cyc_q.push_back(c0 + 10);
        if (!stop_ok) ferr_q.push_back(c0 + 10);
        for (int i = 0; i < 8; i++) begin
            @(posedge sb_clk); #1;
            sbrx = b[i];
        end
        @(posedge sb_clk); #1;
        sbrx = stop_ok;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sb_clk); #1;
            sbrx = 1'b1;
        end
    endtask

    // Scoreboard: every strobe must match the head of the expected queue.
    task automatic monitor_loop();
        logic        prev_v;
        logic [11:0] got;
        logic [11:0] e;
        int          ec;
        prev_v = 1'b0;
        forever begin
            @(negedge sb_clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (rx_valid) begin
                    total_cnt++;
                    if (prev_v) $display("FAIL valid_gap: rx_valid high two cycles running at cycle %0d, required a gap", cyc);
                    else pass_cnt++;
                    got = {rx_err, rx_eop, rx_sop, rx_type, rx_data};
                    total_cnt++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_strobe: got err/eop/sop/type/data=%h at cycle %0d, required no strobe", got, cyc);
                    end else begin
                        e  = exp_q.pop_front();
                        ec = (cyc_q.size() != 0) ? cyc_q.pop_front() : -1;
                        if (got !== e || cyc != ec)
                            $display("FAIL strobe: got %h at cycle %0d, required %h at cycle %0d", got, cyc, e, ec);
                        else pass_cnt++;
                    end
                end
                if (frame_err) begin
                    total_cnt++;
                    if (ferr_q.size() == 0) begin
                        $display("FAIL unexpected_frame_err: pulse at cycle %0d, required none", cyc);
                    end else begin
                        ec = ferr_q.pop_front();
                        if (cyc != ec) $display("FAIL frame_err_cycle: got cycle %0d, required %0d", cyc, ec);
                        else pass_cnt++;
                    end
                end
                prev_v = rx_valid;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; sbrx = 1'b1;
        repeat (3) @(posedge sb_clk);
        @(negedge sb_clk);
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", rx_valid); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h, required 00", rx_data); else pass_cnt++;
        total_cnt++; if (rx_sop !== 1'b0) $display("FAIL reset_sop: got %b, required 0", rx_sop); else pass_cnt++;
        total_cnt++; if (rx_eop !== 1'b0) $display("FAIL reset_eop: got %b, required 0", rx_eop); else pass_cnt++;
        total_cnt++; if (rx_type !== 1'b0) $display("FAIL reset_type: got %b, required 0", rx_type); else pass_cnt++;
        total_cnt++; if (rx_err !== 1'b0) $display("FAIL reset_err: got %b, required 0", rx_err); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b, required 0", frame_err); else pass_cnt++;
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_basic();
        push_exp(8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp(8'h34, 1'b0, 1'b1, 1'b0, 1'b0);
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(STX_CMD, 1'b1, 1'b0);
        send_byte(8'h12, 1'b1, 1'b0);
        send_byte(8'h34, 1'b1, 1'b1);
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(ETX, 1'b1, 1'b1);
        idle(4);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL basic_drain: %0d strobes missing, required 0", exp_q.size()); else pass_cnt++;
        flush_queues();
    endtask

    task automatic test_stuffing();
        push_exp(DLE, 1'b1, 1'b1, 1'b1, 1'b0);
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(STX_RSP, 1'b1, 1'b0);
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(ETX, 1'b1, 1'b1);
        idle(4);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL stuff_drain: %0d strobes missing, required 0", exp_q.size()); else pass_cnt++;
        total_cnt++;
        if (rx_type !== 1'b1) $display("FAIL stuff_type_hold: got %b, required 1", rx_type); else pass_cnt++;
        flush_queues();
    endtask

    task automatic test_frame_error();
        push_exp(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(STX_CMD, 1'b1, 1'b0);
        send_byte(8'hAA, 1'b1, 1'b0);
        send_byte(8'h55, 1'b0, 1'b1);
        idle(4);
        total_cnt++;
        if (exp_q.size() != 0 || ferr_q.size() != 0)
            $display("FAIL ferr_drain: %0d strobes and %0d frame_err pulses missing, required 0", exp_q.size(), ferr_q.size());
        else pass_cnt++;
        flush_queues();
    endtask

    task automatic test_overflow();
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(STX_CMD, 1'b1, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            if (i >= 2 && i <= 16) push_exp(8'(i - 1), (i == 2), 1'b0, 1'b0, 1'b0);
            if (i == 17) push_exp(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
            send_byte(8'(i), 1'b1, (i >= 2));
        end
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(ETX, 1'b1, 1'b0);
        idle(4);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL overflow_drain: %0d strobes missing, required 0", exp_q.size()); else pass_cnt++;
        flush_queues();
    endtask

    task automatic test_empty();
        push_exp(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(STX_CMD, 1'b1, 1'b0);
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(ETX, 1'b1, 1'b1);
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(8'h77, 1'b1, 1'b0);
        idle(4);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL empty_drain: %0d strobes missing, required 0", exp_q.size()); else pass_cnt++;
        flush_queues();
    endtask

    task automatic test_enable();
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(STX_CMD, 1'b1, 1'b0);
        send_byte(8'hAB, 1'b1, 1'b0);
        @(posedge sb_clk); #1;
        enable = 1'b0;
        sbrx   = 1'b0;
        repeat (12) @(posedge sb_clk);
        #1;
        sbrx = 1'b1;
        @(posedge sb_clk); #1;
        enable = 1'b1;
        idle(2);
        // Without a live transaction this DLE/ETX must be ignored.
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(ETX, 1'b1, 1'b0);
        push_exp(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(STX_CMD, 1'b1, 1'b0);
        send_byte(8'h5A, 1'b1, 1'b0);
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(ETX, 1'b1, 1'b1);
        idle(4);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL enable_drain: %0d strobes missing, required 0", exp_q.size()); else pass_cnt++;
        flush_queues();
    endtask

    task automatic test_back_to_back();
        int         n;
        logic       typ;
        logic [7:0] pl[16];
        for (int f = 0; f < 3; f++) begin
            n   = $urandom_range(1, 16);
            typ = 1'($urandom_range(0, 1));
            for (int k = 0; k < 16; k++)
                pl[k] = ($urandom_range(0, 3) == 0) ? DLE : 8'($urandom_range(0, 255));
            send_byte(DLE, 1'b1, 1'b0);
            send_byte(typ ? STX_RSP : STX_CMD, 1'b1, 1'b0);
            for (int k = 0; k < n; k++) begin
                if (k > 0) push_exp(pl[k - 1], (k == 1), 1'b0, typ, 1'b0);
                if (pl[k] == DLE) begin
                    send_byte(DLE, 1'b1, 1'b0);
                    send_byte(DLE, 1'b1, (k > 0));
                end else begin
                    send_byte(pl[k], 1'b1, (k > 0));
                end
            end
            push_exp(pl[n - 1], (n == 1), 1'b1, typ, 1'b0);
            send_byte(DLE, 1'b1, 1'b0);
            send_byte(ETX, 1'b1, 1'b1);
        end
        idle(4);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL b2b_drain: %0d strobes missing, required 0", exp_q.size()); else pass_cnt++;
        flush_queues();
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h22;
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(STX_RSP, 1'b1, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        @(posedge sb_clk); #1;
        sbrx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge sb_clk); #1;
            sbrx = b[i];
        end
        total_cnt++;
        if (rx_type !== 1'b1) $display("FAIL mid_type_before: got %b, required 1", rx_type); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({rx_valid, rx_data, rx_sop, rx_eop, rx_type, rx_err, frame_err} !== 14'h0)
            $display("FAIL mid_reset_outputs: got %h, required 0", {rx_valid, rx_data, rx_sop, rx_eop, rx_type, rx_err, frame_err});
        else pass_cnt++;
        sbrx = 1'b1;
        repeat (2) @(posedge sb_clk);
        @(negedge sb_clk);
        rst = 1'b0;
        idle(2);
        push_exp(8'h9C, 1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(STX_CMD, 1'b1, 1'b0);
        send_byte(8'h9C, 1'b1, 1'b0);
        send_byte(DLE, 1'b1, 1'b0);
        send_byte(ETX, 1'b1, 1'b1);
        idle(4);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL mid_drain: %0d strobes missing, required 0", exp_q.size()); else pass_cnt++;
        flush_queues();
    endtask

    // Watchdog so a stuck run still ends
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required test sequence to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; sbrx = 1'b1;
        fork
            monitor_loop();
        join_none
        test_reset();
        test_basic();
        test_stuffing();
        test_frame_error();
        test_overflow();
        test_empty();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
